// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises and debounces the four board pushbuttons
// (bit order U, D, L, R) in the pixel-clock domain. It produces clean levels,
// one-cycle press strobes and a latched last-pressed direction.
// Optional feature macro: BTN_AUTOREPEAT_EN adds hold-to-repeat press strobes.
module btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 250_000,
   parameter int unsigned REPEAT_DELAY    = 6_250_000,
   parameter int unsigned REPEAT_PERIOD   = 2_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn_raw,
   output logic [3:0] btn_level,
   output logic [3:0] btn_press,
   output logic [1:0] dir,
   output logic       dir_valid
);

   localparam int unsigned NB    = 4;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Reject configurations the counters cannot represent
   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
   end

   logic [NB-1:0]    s1;
   logic [NB-1:0]    s2;
   logic [CNT_W-1:0] cnt      [NB];
   logic [CNT_W-1:0] cnt_next [NB];
   logic [NB-1:0]    level_next;
   logic [NB-1:0]    rise_c;
   logic [NB-1:0]    press_next;
   logic [1:0]       dir_next;
   logic             dir_valid_next;

   // Two-flop synchroniser for the asynchronous button inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
      end
   end

   // Debounce: count consecutive cycles of disagreement, commit after the full window
   always_comb begin
      level_next = btn_level;
      rise_c     = '0;
      for (int i = 0; i < NB; i++) begin
         cnt_next[i] = '0;
         if (s2[i] != btn_level[i]) begin
            if (cnt[i] == CNT_LAST) begin
               level_next[i] = s2[i];
               rise_c[i]     = s2[i];
            end else begin
               cnt_next[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

   logic [HOLD_W-1:0] hold      [NB];
   logic [HOLD_W-1:0] hold_next [NB];
   logic [NB-1:0]     rep_phase;
   logic [NB-1:0]     rep_phase_next;
   logic [NB-1:0]     rep_fire_c;

   // Hold timer: first repeat after the delay, then one per period; any release clears it
   always_comb begin
      rep_phase_next = rep_phase;
      rep_fire_c     = '0;
      for (int i = 0; i < NB; i++) begin
         hold_next[i] = '0;
         if (btn_level[i] && level_next[i]) begin
            if (!rep_phase[i]) begin
               if (hold[i] == DELAY_LAST) begin
                  rep_fire_c[i]     = 1'b1;
                  rep_phase_next[i] = 1'b1;
               end else begin
                  hold_next[i] = hold[i] + HOLD_W'(1);
               end
            end else if (hold[i] == PERIOD_LAST) begin
               rep_fire_c[i] = 1'b1;
            end else begin
               hold_next[i] = hold[i] + HOLD_W'(1);
            end
         end else begin
            rep_phase_next[i] = 1'b0;
         end
      end
      press_next = rise_c | rep_fire_c;
   end

   // Hold timer state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_phase <= '0;
         for (int i = 0; i < NB; i++) hold[i] <= '0;
      end else begin
         rep_phase <= rep_phase_next;
         for (int i = 0; i < NB; i++) hold[i] <= hold_next[i];
      end
   end
`else
   // Strobe only on an accepted press
   always_comb begin
      press_next = rise_c;
   end
`endif

   // Latch the lowest-numbered strobing button as the requested direction
   always_comb begin
      dir_next       = dir;
      dir_valid_next = dir_valid;
      if (|btn_press) begin
         dir_valid_next = 1'b1;
         if (btn_press[0])      dir_next = 2'd0;
         else if (btn_press[1]) dir_next = 2'd1;
         else if (btn_press[2]) dir_next = 2'd2;
         else                   dir_next = 2'd3;
      end
   end

   // Debounce counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_level <= '0;
         btn_press <= '0;
         dir       <= '0;
         dir_valid <= 1'b0;
         for (int i = 0; i < NB; i++) cnt[i] <= '0;
      end else begin
         btn_level <= level_next;
         btn_press <= press_next;
         dir       <= dir_next;
         dir_valid <= dir_valid_next;
         for (int i = 0; i < NB; i++) cnt[i] <= cnt_next[i];
      end
   end

endmodule
